// File: rtl/counter_sched.sv
// Round-robin owner arbitration for a single shared counter macro.
// Each grant clears the counter, runs it up to the latched target, then pulses done.
module counter_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
`ifdef USE_POWER_PINS
  inout  wire                    vccd1,
  inout  wire                    vssd1,
`endif
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  target,
  input  logic [WIDTH-1:0]       cnt_value,
  output logic                   cnt_enable,
  output logic                   cnt_clear,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic                   busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    FIN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nx;
  logic [IW-1:0]    idx_inc;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    rr_nx;
  logic [IW-1:0]    pick;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] tgt_nx;
  logic             found;
  logic             own_req;
  logic [NREQ-1:0]  owner;

  assign idx_inc = (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
  assign own_req = req[idx];
  assign owner   = NREQ'(1) << idx;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin : pick_blk
    int pos;
    found = 1'b0;
    pick  = '0;
    pos   = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos = (int'(rr_ptr) + i) % NREQ;
      if (!found && req[pos]) begin
        found = 1'b1;
        pick  = IW'(pos);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    tgt_nx     = tgt;
    rr_nx      = rr_ptr;
    cnt_enable = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          idx_nx   = pick;
          tgt_nx   = target[int'(pick)*WIDTH +: WIDTH];
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        if (!own_req) begin
          state_nx = IDLE;
          rr_nx    = idx_inc;
        end else begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!own_req) begin
          state_nx = IDLE;
          rr_nx    = idx_inc;
        end else if (cnt_value == tgt) begin
          state_nx = FIN;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      FIN: begin
        state_nx = IDLE;
        rr_nx    = idx_inc;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      tgt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      tgt    <= tgt_nx;
      rr_ptr <= rr_nx;
    end
  end

  assign busy      = (state != IDLE);
  assign cnt_clear = (state == CLEAR);
  assign grant     = busy ? owner : '0;
  assign done      = (state == FIN) ? owner : '0;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural 4-bit counter macro.
// Checks {grant,done,busy,cnt_enable,cnt_clear} cycle by cycle per scenario.
module tb_counter_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] target;
  logic [3:0]  cnt_value = '0;
  logic        cnt_enable;
  logic        cnt_clear;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
`ifdef USE_POWER_PINS
  wire         vccd1;
  wire         vssd1;
`endif

  int          total = 0;
  int          bad = 0;
  logic [10:0] obs;
  logic [10:0] expv;

  counter_sched #(.NREQ(4), .WIDTH(4)) dut (
`ifdef USE_POWER_PINS
    .vccd1      (vccd1),
    .vssd1      (vssd1),
`endif
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .target     (target),
    .cnt_value  (cnt_value),
    .cnt_enable (cnt_enable),
    .cnt_clear  (cnt_clear),
    .grant      (grant),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_clear)
      cnt_value <= '0;
    else if (cnt_enable)
      cnt_value <= cnt_value + 1'b1;
  end

  assign obs = {grant, done, busy, cnt_enable, cnt_clear};

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    req    = '0;
    target = '0;
    reset  = 1'b1;
    tick();
    total++;
    if (obs !== 11'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=%b", obs, 11'b0);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single;
    req    = 4'b0001;
    target = 16'h0005;
    #1;
    for (int c = 0; c < 10; c++) begin
      expv = '0;
      if (c >= 1 && c <= 8) expv[10:7] = 4'b0001;
      if (c == 8)           expv[6:3]  = 4'b0001;
      if (c >= 1 && c <= 8) expv[2]    = 1'b1;
      if (c >= 2 && c <= 6) expv[1]    = 1'b1;
      if (c == 1)           expv[0]    = 1'b1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL single c=%0d got=%b exp=%b", c, obs, expv);
      end
      if (c == 8) req = '0;
      tick();
    end
  endtask

  task automatic test_zero;
    req    = 4'b0001;
    target = 16'h0000;
    #1;
    for (int c = 0; c < 5; c++) begin
      expv = '0;
      if (c >= 1 && c <= 3) expv[10:7] = 4'b0001;
      if (c == 3)           expv[6:3]  = 4'b0001;
      if (c >= 1 && c <= 3) expv[2]    = 1'b1;
      if (c == 1)           expv[0]    = 1'b1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL zero c=%0d got=%b exp=%b", c, obs, expv);
      end
      if (c >= 2) begin
        total++;
        if (cnt_value !== 4'd0) begin
          bad++;
          $display("FAIL zero_cnt c=%0d got=%0d exp=0", c, cnt_value);
        end
      end
      if (c == 3) req = '0;
      tick();
    end
  endtask

  task automatic test_round_robin;
    int gs[4];
    int ds[4];
    gs = '{1, 6, 12, 19};
    ds = '{4, 10, 17, 25};
    test_reset();
    req    = 4'b1111;
    target = 16'h4321;
    #1;
    for (int c = 0; c < 28; c++) begin
      expv = '0;
      for (int k = 0; k < 4; k++) begin
        if (c >= gs[k] && c <= ds[k]) begin
          expv[10:7] = 4'(1 << k);
          expv[2]    = 1'b1;
        end
        if (c == ds[k])                        expv[6:3] = 4'(1 << k);
        if (c >= gs[k] + 1 && c <= ds[k] - 2)  expv[1]   = 1'b1;
        if (c == gs[k])                        expv[0]   = 1'b1;
      end
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL rr c=%0d got=%b exp=%b", c, obs, expv);
      end
      for (int k = 0; k < 4; k++)
        if (c == ds[k]) req[k] = 1'b0;
      tick();
    end
  endtask

  task automatic test_rr_pointer;
    req    = 4'b0010;
    target = 16'h0000;
    #1;
    for (int c = 0; c < 13; c++) begin
      if (c == 4) begin
        req = 4'b0101;
        #1;
      end
      if (c == 5 || c == 7 || c == 9 || c == 11 || c == 12) begin
        expv = '0;
        if (c == 5 || c == 7)   expv[10:7] = 4'b0100;
        if (c == 9 || c == 11)  expv[10:7] = 4'b0001;
        if (c == 7)             expv[6:3]  = 4'b0100;
        if (c == 11)            expv[6:3]  = 4'b0001;
        if (c != 12)            expv[2]    = 1'b1;
        if (c == 5 || c == 9)   expv[0]    = 1'b1;
        total++;
        if (obs !== expv) begin
          bad++;
          $display("FAIL rr_ptr c=%0d got=%b exp=%b", c, obs, expv);
        end
      end
      if (c == 3)  req[1] = 1'b0;
      if (c == 7)  req[2] = 1'b0;
      if (c == 11) req[0] = 1'b0;
      tick();
    end
  endtask

  task automatic test_abort;
    req    = 4'b0100;
    target = 16'h0600;
    #1;
    for (int c = 0; c < 9; c++) begin
      if (c == 5) begin
        total++;
        if (cnt_value !== 4'd3 || cnt_enable !== 1'b1) begin
          bad++;
          $display("FAIL abort_pre cnt=%0d en=%b exp cnt=3 en=1",
                   cnt_value, cnt_enable);
        end
        req = '0;
        #1;
        total++;
        if (cnt_enable !== 1'b0 || grant !== 4'b0100) begin
          bad++;
          $display("FAIL abort_now en=%b grant=%b exp en=0 grant=0100",
                   cnt_enable, grant);
        end
      end
      if (c >= 6) begin
        total++;
        if (obs !== 11'b0 || cnt_value !== 4'd3) begin
          bad++;
          $display("FAIL abort_after c=%0d got=%b cnt=%0d exp=0 cnt=3",
                   c, obs, cnt_value);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset;
    req    = 4'b0001;
    target = 16'h0009;
    #1;
    for (int c = 0; c < 5; c++) tick();
    req = 4'b1001;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (obs !== 11'b0) begin
      bad++;
      $display("FAIL async_reset got=%b exp=%b", obs, 11'b0);
    end
    #1;
    reset = 1'b0;
    tick();
    total++;
    if (obs !== 11'b00010000101) begin
      bad++;
      $display("FAIL regrant got=%b exp=%b", obs, 11'b00010000101);
    end
    tick();
    total++;
    if (cnt_value !== 4'd0 || grant !== 4'b0001) begin
      bad++;
      $display("FAIL regrant_run cnt=%0d grant=%b exp cnt=0 grant=0001",
               cnt_value, grant);
    end
    req = '0;
    tick();
    total++;
    if (obs !== 11'b0) begin
      bad++;
      $display("FAIL regrant_drop got=%b exp=%b", obs, 11'b0);
    end
  endtask

  task automatic test_max;
    int en_cnt;
    en_cnt = 0;
    req    = 4'b0001;
    target = 16'h000f;
    #1;
    for (int c = 0; c < 21; c++) begin
      if (cnt_enable === 1'b1) en_cnt++;
      if (c == 17 || c == 19 || c == 20) begin
        total++;
        if (cnt_value !== 4'd15) begin
          bad++;
          $display("FAIL max_cnt c=%0d got=%0d exp=15", c, cnt_value);
        end
      end
      if (c == 18) begin
        total++;
        if (done !== 4'b0001 || busy !== 1'b1) begin
          bad++;
          $display("FAIL max_done done=%b busy=%b exp done=0001 busy=1",
                   done, busy);
        end
        req = '0;
      end
      if (c == 19) begin
        total++;
        if (obs !== 11'b0) begin
          bad++;
          $display("FAIL max_idle got=%b exp=%b", obs, 11'b0);
        end
      end
      tick();
    end
    total++;
    if (en_cnt != 15) begin
      bad++;
      $display("FAIL max_en_cycles got=%0d exp=15", en_cnt);
    end
  endtask

  initial begin
    reset  = 1'b1;
    req    = '0;
    target = '0;
    #3;
    test_reset();
    test_single();
    test_zero();
    test_round_robin();
    test_rr_pointer();
    test_abort();
    test_async_reset();
    test_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
